// File: rtl/wave_frame_pkg.sv
// wave_frame_pkg: constants and state types shared by the waveform frame receive and transmit sides
// Holds the frame header bytes, default link/frame sizing and the FSM state enums.
package wave_frame_pkg;
    localparam logic [7:0] HDR_BYTE0        = 8'hAA;
    localparam logic [7:0] HDR_BYTE1        = 8'h55;
    localparam int         DEF_CLKS_PER_BIT = 434;
    localparam int         DEF_N_SAMPLES    = 1000;
    localparam int         DEF_TIMEOUT_BITS = 40;
    typedef enum logic [2:0] {IDLE, HDR, WN_HI, WN_LO, S_HI, S_LO, CKSUM} frame_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver with input synchronizer and framing-error detection
// Ports: clk_50 clock; reset sync active-high; rx raw serial line (idle high);
//        rx_data received byte, valid with rx_valid (1-cycle pulse); rx_ferr 1-cycle pulse on bad stop bit.
import wave_frame_pkg::*;

module uart_rx_byte #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    rx_state_t state, state_d;
    logic [1:0]    sync;
    logic          prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          line, fall, half_hit, bit_hit;
    assign line     = sync[1];
    assign fall     = prev & ~line;
    assign half_hit = cnt == CW'(HALF - 1);
    assign bit_hit  = cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk_50) state <= reset ? RX_IDLE : state_d;
    always_comb begin
        state_d = state;
        case (state)
            RX_IDLE:  state_d = fall ? RX_START : RX_IDLE;
            RX_START: if (half_hit) state_d = line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_hit && bit_idx == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (bit_hit) state_d = line ? RX_IDLE : RX_WAIT;
            RX_WAIT:  if (line) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end
    always_ff @(posedge clk_50) begin
        if (reset) begin
            sync     <= 2'b11;
            prev     <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            sync     <= {sync[0], rx};
            prev     <= line;
            rx_valid <= state == RX_STOP && bit_hit && line;
            rx_ferr  <= state == RX_STOP && bit_hit && !line;
            cnt      <= (state_d != state || bit_hit || state == RX_IDLE) ? '0 : cnt + 1'b1;
            if (state == RX_START) bit_idx <= '0;
            if (state == RX_DATA && bit_hit) begin
                shift   <= {line, shift[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == RX_STOP && bit_hit && line) rx_data <= shift;
        end
    end
endmodule

// File: rtl/wave_frame_rx.sv
// wave_frame_rx: decodes checksummed waveform frames from a UART byte stream into 14-bit samples
// Ports: clk_50 clock; reset sync active-high; UART_RX serial input;
//        sample_valid/sample_data/sample_idx decoded sample stream; wave_number of current frame;
//        frame_done good-checksum pulse; frame_err abort/bad-checksum pulse; busy frame body in progress.
import wave_frame_pkg::*;

module wave_frame_rx #(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int N_SAMPLES    = DEF_N_SAMPLES,
    parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        UART_RX,
    output logic        sample_valid,
    output logic [13:0] sample_data,
    output logic [9:0]  sample_idx,
    output logic [15:0] wave_number,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW     = $clog2(TO_CYC + 1);
    frame_state_t state, state_d;
    logic [7:0]    rx_data, wn_hi, cksum;
    logic          rx_valid, rx_ferr;
    logic [5:0]    s_hi;
    logic [9:0]    idx;
    logic [TW-1:0] timer;
    logic          in_frame, timeout, last, done, abort;
    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_50   (clk_50),
        .reset    (reset),
        .rx       (UART_RX),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );
    assign in_frame = state inside {WN_HI, WN_LO, S_HI, S_LO, CKSUM};
    assign timeout  = in_frame && timer == TW'(TO_CYC);
    assign last     = idx == 10'(N_SAMPLES - 1);
    always_ff @(posedge clk_50) state <= reset ? IDLE : state_d;
    always_comb begin
        state_d = state;
        done    = 1'b0;
        abort   = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE:    state_d = rx_data == HDR_BYTE0 ? HDR : IDLE;
                HDR:     state_d = rx_data == HDR_BYTE1 ? WN_HI : rx_data == HDR_BYTE0 ? HDR : IDLE;
                WN_HI:   state_d = WN_LO;
                WN_LO:   state_d = S_HI;
                S_HI: begin
                    abort   = |rx_data[7:6];
                    state_d = abort ? IDLE : S_LO;
                end
                S_LO:    state_d = last ? CKSUM : S_HI;
                CKSUM: begin
                    done    = rx_data == cksum;
                    abort   = !done;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (rx_ferr || timeout) begin
            // outside the frame body a bad byte only restarts header hunting, silently
            abort   = in_frame;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk_50) begin
        if (reset) begin
            sample_valid <= 1'b0;
            sample_data  <= '0;
            sample_idx   <= '0;
            wave_number  <= '0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
            wn_hi        <= '0;
            s_hi         <= '0;
            cksum        <= '0;
            idx          <= '0;
            timer        <= '0;
        end else begin
            sample_valid <= rx_valid && state == S_LO;
            frame_done   <= done;
            frame_err    <= abort;
            timer        <= (in_frame && !rx_valid && !abort) ? timer + 1'b1 : '0;
            if (done || abort) busy <= 1'b0;
            if (rx_valid) begin
                case (state)
                    HDR:   idx <= '0;
                    WN_HI: begin
                        wn_hi <= rx_data;
                        cksum <= rx_data;
                    end
                    WN_LO: begin
                        wave_number <= {wn_hi, rx_data};
                        cksum       <= cksum ^ rx_data;
                        busy        <= 1'b1;
                    end
                    S_HI: begin
                        s_hi  <= rx_data[5:0];
                        cksum <= cksum ^ rx_data;
                    end
                    S_LO: begin
                        sample_data <= {s_hi, rx_data};
                        sample_idx  <= idx;
                        idx         <= idx + 1'b1;
                        cksum       <= cksum ^ rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wave_frame_rx.sv
// tb_wave_frame_rx: self-checking bench for wave_frame_rx using a byte-stream reference parser
module tb_wave_frame_rx;
    localparam int CPB = 8;
    localparam int NS  = 12;
    localparam int TOB = 40;
    typedef logic [7:0]  bq_t[$];
    typedef logic [13:0] sq_t[$];
    typedef struct packed {logic [13:0] d; logic [9:0] i;} samp_t;
    typedef struct {logic [15:0] wn; int step; logic [7:0] cx; int bad; int n; int d; int e;} vec_t;
    logic        clk_50, reset, UART_RX;
    logic        sample_valid, frame_done, frame_err, busy;
    logic [13:0] sample_data;
    logic [9:0]  sample_idx;
    logic [15:0] wave_number;
    int          checks, errors;
    samp_t       obs_q[$], exp_q[$];
    int          obs_done, obs_err, obs_both, obs_busy_bad;
    int          obs_rd, done_base, err_base;
    logic [15:0] exp_wn;
    vec_t        tbl[5];

    wave_frame_rx #(.CLKS_PER_BIT(CPB), .N_SAMPLES(NS), .TIMEOUT_BITS(TOB)) dut (
        .clk_50       (clk_50),
        .reset        (reset),
        .UART_RX      (UART_RX),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_idx   (sample_idx),
        .wave_number  (wave_number),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    initial begin
        obs_done = 0;
        obs_err = 0;
        obs_both = 0;
        obs_busy_bad = 0;
    end

    always @(negedge clk_50) begin
        if (sample_valid) obs_q.push_back({sample_data, sample_idx});
        if (sample_valid && !busy) obs_busy_bad++;
        if ((frame_done || frame_err) && busy) obs_busy_bad++;
        if (frame_done && frame_err) obs_both++;
        if (frame_done) obs_done++;
        if (frame_err) obs_err++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        UART_RX = 1'b0;
        repeat (CPB) @(negedge clk_50);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (CPB) @(negedge clk_50);
        end
        UART_RX = 1'b1;
        repeat (CPB * (1 + gap)) @(negedge clk_50);
    endtask

    task automatic send_stream(input bq_t q, input int maxgap);
        foreach (q[k]) send_byte(q[k], $urandom_range(0, maxgap));
    endtask

    task automatic settle(input int bits);
        repeat (bits * CPB) @(negedge clk_50);
    endtask

    task automatic mk_samples(input int step, input logic rnd, output sq_t s);
        s = {};
        for (int k = 0; k < NS; k++) s.push_back(rnd ? 14'($urandom) : 14'(k * step));
    endtask

    task automatic build_frame(input logic [15:0] wn, input sq_t s, input logic [7:0] cx, input int bad, output bq_t q);
        logic [7:0] c, hi, lo;
        q = {8'hAA, 8'h55, wn[15:8], wn[7:0]};
        c = wn[15:8] ^ wn[7:0];
        for (int k = 0; k < NS; k++) begin
            hi = (k == bad) ? 8'h40 : {2'b00, s[k][13:8]};
            lo = s[k][7:0];
            q.push_back(hi);
            if (k == bad) return;
            q.push_back(lo);
            c = c ^ hi ^ lo;
        end
        q.push_back(c ^ cx);
    endtask

    // Reference parser: a frame starts at the first AA,55 pair; a stream that ends inside a
    // frame body is expected to time out with frame_err.
    task automatic model(input bq_t s, output int nd, output int ne);
        int p;
        logic [7:0] c, hi, lo;
        logic stop;
        nd = 0;
        ne = 0;
        p = 0;
        while (p + 1 < s.size()) begin
            if (s[p] != 8'hAA || s[p+1] != 8'h55) begin
                p++;
                continue;
            end
            p += 2;
            if (p + 1 >= s.size()) begin
                ne++;
                return;
            end
            exp_wn = {s[p], s[p+1]};
            c = s[p] ^ s[p+1];
            p += 2;
            stop = 1'b0;
            for (int k = 0; k < NS && !stop; k++) begin
                if (p >= s.size()) begin
                    ne++;
                    return;
                end
                hi = s[p];
                if (hi[7:6] != 2'b00) begin
                    ne++;
                    p++;
                    stop = 1'b1;
                end else begin
                    if (p + 1 >= s.size()) begin
                        ne++;
                        return;
                    end
                    lo = s[p+1];
                    exp_q.push_back({hi[5:0], lo, 10'(k)});
                    c = c ^ hi ^ lo;
                    p += 2;
                end
            end
            if (!stop) begin
                if (p >= s.size()) begin
                    ne++;
                    return;
                end
                if (s[p] == c) nd++;
                else ne++;
                p++;
            end
        end
    endtask

    task automatic checkpoint(input string nm, input int n, input int d, input int e);
        int got;
        got = obs_q.size() - obs_rd;
        check({nm, " count"}, got, n);
        for (int k = 0; k < got && k < exp_q.size(); k++) begin
            check($sformatf("%s data%0d", nm, k), 32'(obs_q[obs_rd+k].d), 32'(exp_q[k].d));
            check($sformatf("%s idx%0d", nm, k), 32'(obs_q[obs_rd+k].i), 32'(exp_q[k].i));
        end
        check({nm, " done"}, obs_done - done_base, d);
        check({nm, " err"}, obs_err - err_base, e);
        check({nm, " wave_number"}, 32'(wave_number), 32'(exp_wn));
        check({nm, " busy"}, 32'(busy), 0);
        check({nm, " done_and_err"}, obs_both, 0);
        check({nm, " busy_at_pulse"}, obs_busy_bad, 0);
        obs_rd = obs_q.size();
        exp_q.delete();
        done_base = obs_done;
        err_base = obs_err;
    endtask

    initial begin
        bq_t q, g;
        sq_t s;
        int nd, ne, kind, cut;
        checks = 0;
        errors = 0;
        obs_rd = 0;
        done_base = 0;
        err_base = 0;
        exp_wn = '0;
        tbl[0] = '{16'h0123, 16,   8'h00, -1, 12, 1, 0};
        tbl[1] = '{16'h0123, 16,   8'h01, -1, 12, 0, 1};
        tbl[2] = '{16'hBEEF, 1365, 8'h00,  5,  5, 0, 1};
        tbl[3] = '{16'hFFFF, 1489, 8'h00,  0,  0, 0, 1};
        tbl[4] = '{16'h0000, 1489, 8'hFF, -1, 12, 0, 1};
        UART_RX = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk_50);
        check("rst sample_valid", 32'(sample_valid), 0);
        check("rst sample_data", 32'(sample_data), 0);
        check("rst sample_idx", 32'(sample_idx), 0);
        check("rst wave_number", 32'(wave_number), 0);
        check("rst frame_done", 32'(frame_done), 0);
        check("rst frame_err", 32'(frame_err), 0);
        check("rst busy", 32'(busy), 0);
        reset = 1'b0;
        settle(2);
        for (int t = 0; t < 5; t++) begin
            mk_samples(tbl[t].step, 1'b0, s);
            build_frame(tbl[t].wn, s, tbl[t].cx, tbl[t].bad, q);
            model(q, nd, ne);
            send_stream(q, 0);
            settle(50);
            checkpoint($sformatf("vec%0d", t), tbl[t].n, tbl[t].d, tbl[t].e);
        end
        mk_samples(16, 1'b0, s);
        build_frame(16'h0123, s, 8'h00, -1, g);
        q = {8'h12, 8'hAA};
        foreach (g[k]) q.push_back(g[k]);
        model(q, nd, ne);
        send_stream(q, 0);
        settle(50);
        checkpoint("garbage_hdr", NS, 1, 0);
        mk_samples(3, 1'b0, s);
        build_frame(16'h0456, s, 8'h00, -1, q);
        q = q[0:23];
        model(q, nd, ne);
        send_stream(q, 0);
        settle(30);
        check("timeout early", obs_err - err_base, 0);
        settle(20);
        checkpoint("timeout", 10, 0, 1);
        mk_samples(5, 1'b0, s);
        build_frame(16'h0A0B, s, 8'h00, -1, q);
        model(q, nd, ne);
        send_stream(q, 0);
        settle(50);
        checkpoint("after_timeout", NS, 1, 0);
        mk_samples(7, 1'b0, s);
        build_frame(16'h0777, s, 8'h00, -1, q);
        for (int k = 0; k < 20; k++) send_byte(q[k], 0);
        for (int k = 0; k < 8; k++) exp_q.push_back({14'(k * 7), 10'(k)});
        UART_RX = 1'b0;
        repeat (CPB) @(negedge clk_50);
        UART_RX = q[20][0];
        repeat (2 * CPB) @(negedge clk_50);
        reset = 1'b1;
        repeat (3) @(negedge clk_50);
        reset = 1'b0;
        UART_RX = 1'b1;
        exp_wn = '0;
        settle(50);
        checkpoint("reset_mid", 8, 0, 0);
        check("reset_mid sample_idx", 32'(sample_idx), 0);
        check("reset_mid sample_data", 32'(sample_data), 0);
        model(q, nd, ne);
        send_stream(q, 0);
        settle(50);
        checkpoint("after_reset", NS, 1, 0);
        for (int r = 0; r < 6; r++) begin
            kind = $urandom_range(0, 3);
            mk_samples(0, 1'b1, s);
            build_frame(16'($urandom), s, kind == 1 ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
                        kind == 2 ? $urandom_range(0, NS - 1) : -1, g);
            if (kind == 3) begin
                cut = $urandom_range(3, g.size() - 1);
                g = g[0:cut-1];
            end
            q = {};
            repeat ($urandom_range(0, 2)) q.push_back(8'($urandom_range(0, 8'h54)));
            foreach (g[k]) q.push_back(g[k]);
            model(q, nd, ne);
            send_stream(q, 2);
            settle(50);
            checkpoint($sformatf("rand%0d", r), exp_q.size(), nd, ne);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wave_frame_rx.md
WAVE_FRAME_RX -- requirements
Module: wave_frame_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk_50 cycles per UART bit (115200 baud).
REQ-002 SHALL have parameter N_SAMPLES, default 1000, meaning samples per waveform frame.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 40, meaning idle bit-times tolerated between bytes inside a frame.
REQ-004 SHALL have port clk_50  input  1  the only clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port UART_RX  input  1  asynchronous serial line, 8N1, idle high.
REQ-007 SHALL have port sample_valid  output  1  one-cycle pulse per decoded sample.
REQ-008 SHALL have port sample_data  output  14  decoded sample, valid with sample_valid.
REQ-009 SHALL have port sample_idx  output  10  sample index 0..N_SAMPLES-1, valid with sample_valid.
REQ-010 SHALL have port wave_number  output  16  waveform number of the current frame, held until the next header.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse, frame checksum good.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse, frame aborted or checksum bad.
REQ-013 SHALL have port busy  output  1  high from header completion until frame_done/frame_err.

Function
REQ-014 UART_RX SHALL pass through a 2-flop synchronizer; the start bit is a high-to-low transition of the synchronized line.
REQ-015 Byte receiver SHALL re-sample at CLKS_PER_BIT/2 after the edge; if the line is high there, the start is dropped and the receiver returns to idle.
REQ-016 Receiver SHALL sample 8 data bits LSB-first at CLKS_PER_BIT intervals, then the stop bit; stop low = framing error: byte discarded, rx_ferr pulse, receiver waits for line high before rearming.
REQ-017 Frame format SHALL be: 0xAA, 0x55, wave_number MSB, wave_number LSB, N_SAMPLES x (sample high byte, sample low byte), checksum byte.
REQ-018 Frame FSM states SHALL be IDLE, HDR, WN_HI, WN_LO, S_HI, S_LO, CKSUM.
REQ-019 IDLE: 0xAA -> HDR; else stay. HDR: 0x55 -> WN_HI; 0xAA -> stay in HDR; else -> IDLE; no frame_err in IDLE/HDR.
REQ-020 WN_LO completion SHALL update wave_number and raise busy in the same cycle.
REQ-021 S_HI byte bits [7:6] nonzero SHALL abort: frame_err pulse, -> IDLE.
REQ-022 S_LO completion SHALL pulse sample_valid the next cycle with sample_data = {hi[5:0], lo}, sample_idx = running count.
REQ-023 After sample index N_SAMPLES-1 the FSM SHALL go to CKSUM; sample counter SHALL reset to 0 on every header.
REQ-024 Checksum SHALL be the 8-bit XOR of all bytes from wave_number MSB through the last sample low byte; match -> frame_done, mismatch -> frame_err; both one cycle after the checksum byte; -> IDLE.
REQ-025 In WN_HI..CKSUM, a framing error or TIMEOUT_BITS*CLKS_PER_BIT cycles with no completed byte SHALL produce frame_err and -> IDLE.
REQ-026 frame_done and frame_err SHALL never assert in the same cycle; busy SHALL drop in the cycle either pulses.
REQ-027 Samples already emitted before an abort SHALL not be retracted; consumers use frame_done to commit.

Reset
REQ-028 Reset SHALL force: FSM IDLE, receiver idle, sample_valid/frame_done/frame_err/busy 0, sample_data 0, sample_idx 0, wave_number 0, checksum 0, timers 0.
REQ-029 Reset asserted mid-byte or mid-frame SHALL discard all partial state with no frame_err pulse.

Structure
REQ-030 Shared package wave_frame_pkg SHALL hold header constants 0xAA/0x55, the FSM state enum, and default baud/sample-count constants, shared with the transmit side.
REQ-031 Byte-level receiver SHALL be sub-module uart_rx_byte (outputs rx_data[7:0], rx_valid, rx_ferr); frame FSM lives in wave_frame_rx.

Verification
REQ-032 Good frame, wave_number 0x0123, samples i*16 (i=0..999), correct checksum -> 1000 sample_valid pulses with matching data/idx, wave_number 0x0123, one frame_done, no frame_err.
REQ-033 Same frame with checksum byte XOR 0x01 -> 1000 samples, then frame_err, no frame_done.
REQ-034 Garbage 0x12, 0xAA, 0xAA, 0x55 then valid frame -> frame decoded normally, no frame_err.
REQ-035 Sample 5 high byte 0x40 -> exactly 5 sample_valid pulses, frame_err, FSM IDLE.
REQ-036 Line held idle 50 bit-times after sample 10 -> frame_err once timeout expires; next valid frame decodes.
REQ-037 Reset pulse during sample 300, then full valid frame -> no frame_err from the aborted frame, sample_idx restarts at 0, frame_done.
